// File: rtl/prbs8_pkg.sv
// ============================================================================
// Module      : prbs8_pkg
// Description : Shared definitions for the 8-bit Fibonacci LFSR generator and
//               checker: polynomial, seed, checker state type, helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prbs8_pkg;

  localparam int              LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;
  // Feedback taps: bits 7, 3, 2 and 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1000_1110;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs8_checker_if.sv
// ============================================================================
// Module      : prbs8_checker_if
// Description : Data/status bundle between a word source and prbs8_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prbs8_checker_if #(
  parameter int CNT_W = 16
);

  logic             en;
  logic [7:0]       data_in;
  logic             clr_count;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output en, data_in, clr_count,
    input  locked, err, err_count
  );

  modport slave (
    input  en, data_in, clr_count,
    output locked, err, err_count
  );

endinterface

`default_nettype wire

// File: rtl/prbs8_checker.sv
// ============================================================================
// Module      : prbs8_checker
// Description : Self-synchronising checker for the 8-bit LFSR word stream.
//               Define PRBS_CHK_BITERR_EN to count bit errors, not word errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  prbs8_checker_if.slave   bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(UNLOCK_CNT + 1);
  localparam int SW = ((CNT_W > 4) ? CNT_W : 4) + 1;

  localparam logic [MW-1:0]    c_lock_last   = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0]    c_unlock_last = XW'(UNLOCK_CNT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  chk_state_t         r_st,        w_st;
  logic [LFSR_W-1:0]  r_ref,       w_ref;
  logic               r_have_ref,  w_have_ref;
  logic [MW-1:0]      r_match_cnt, w_match_cnt;
  logic [XW-1:0]      r_miss_cnt,  w_miss_cnt;
  logic               r_err,       w_err;
  logic [CNT_W-1:0]   r_err_count, w_err_count;

  logic [LFSR_W-1:0]  w_exp;
  logic               w_mismatch;
  logic               w_bump;
  logic [3:0]         w_inc;
  logic [SW-1:0]      w_sum;

  always_comb begin
    w_exp      = lfsr8_next(r_ref);
    w_mismatch = (bus.data_in != w_exp);
`ifdef PRBS_CHK_BITERR_EN
    w_inc      = popcount8(bus.data_in ^ w_exp);
`else
    w_inc      = 4'd1;
`endif

    w_st        = r_st;
    w_ref       = r_ref;
    w_have_ref  = r_have_ref;
    w_match_cnt = r_match_cnt;
    w_miss_cnt  = r_miss_cnt;
    w_err       = 1'b0;
    w_bump      = 1'b0;

    if (bus.en) begin
      case (r_st)
        HUNT: begin
          if (bus.data_in == '0) begin
            w_have_ref  = 1'b0;
            w_match_cnt = '0;
          end else begin
            w_ref      = bus.data_in;
            w_have_ref = 1'b1;
            if (r_have_ref && !w_mismatch) begin
              w_match_cnt = r_match_cnt + MW'(1);
              if (r_match_cnt == c_lock_last) begin
                w_st       = LOCKED;
                w_miss_cnt = '0;
              end
            end else begin
              w_match_cnt = '0;
            end
          end
        end
        LOCKED: begin
          // Free-run the reference so an isolated bad word cannot derail it.
          w_ref = w_exp;
          if (w_mismatch) begin
            w_err      = 1'b1;
            w_bump     = 1'b1;
            w_miss_cnt = r_miss_cnt + XW'(1);
            if (r_miss_cnt == c_unlock_last) begin
              w_st        = HUNT;
              w_match_cnt = '0;
              w_ref       = bus.data_in;
              w_have_ref  = (bus.data_in != '0);
            end
          end else begin
            w_miss_cnt = '0;
          end
        end
        default: w_st = HUNT;
      endcase
    end

    // Widened sum so a multi-bit increment cannot wrap past all-ones.
    w_sum       = SW'(r_err_count) + SW'(w_inc);
    w_err_count = r_err_count;
    if (bus.clr_count) begin
      w_err_count = '0;
    end else if (w_bump) begin
      w_err_count = (w_sum > SW'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= HUNT;
      r_ref       <= '0;
      r_have_ref  <= 1'b0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_st        <= w_st;
      r_ref       <= w_ref;
      r_have_ref  <= w_have_ref;
      r_match_cnt <= w_match_cnt;
      r_miss_cnt  <= w_miss_cnt;
      r_err       <= w_err;
      r_err_count <= w_err_count;
    end
  end

  assign bus.locked    = (r_st == LOCKED);
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_prbs8_checker.sv
// ============================================================================
// Module      : tb_prbs8_checker
// Description : Scoreboard bench for prbs8_checker (16-bit and 2-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs8_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int MAX_A      = 65535;
  localparam int MAX_B      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs8_checker_if #(.CNT_W(16)) bus_a ();
  prbs8_checker_if #(.CNT_W(2))  bus_b ();

  assign bus_b.en        = bus_a.en;
  assign bus_b.data_in   = bus_a.data_in;
  assign bus_b.clr_count = bus_a.clr_count;

  prbs8_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  prbs8_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit locked;
    bit err;
    int cnt_a;
    int cnt_b;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the generator polynomial as plain arithmetic.
  function automatic int gnext(input int s);
    return ((s << 1) & 255) | ($countones(s & 8'h8E) & 1);
  endfunction

  bit m_locked, m_have, m_err;
  int m_ref, m_match, m_miss, m_cnt_a, m_cnt_b;

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_err = 0;
    m_ref = 0; m_match = 0; m_miss = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_beat(input bit en, input int d, input bit clr);
    int e;
    int inc;
    m_err = 0;
    if (en) begin
      e = gnext(m_ref);
      if (!m_locked) begin
        if (d == 0) begin
          m_have = 0; m_match = 0;
        end else begin
          if (m_have && d == e) m_match++;
          else m_match = 0;
          m_ref  = d;
          m_have = 1;
          if (m_match == LOCK_CNT) begin
            m_locked = 1; m_miss = 0;
          end
        end
      end else begin
        m_ref = e;
        if (d != e) begin
`ifdef PRBS_CHK_BITERR_EN
          inc = $countones(d ^ e);
`else
          inc = 1;
`endif
          m_err   = 1;
          m_cnt_a = (m_cnt_a + inc > MAX_A) ? MAX_A : m_cnt_a + inc;
          m_cnt_b = (m_cnt_b + inc > MAX_B) ? MAX_B : m_cnt_b + inc;
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin
            m_locked = 0; m_match = 0; m_ref = d; m_have = (d != 0);
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end
  endtask

  task automatic beat(input bit en, input int d, input bit clr);
    exp_t x;
    bus_a.en        = en;
    bus_a.data_in   = 8'(d);
    bus_a.clr_count = clr;
    model_beat(en, d, clr);
    x.due = cyc + 1; x.locked = m_locked; x.err = m_err;
    x.cnt_a = m_cnt_a; x.cnt_b = m_cnt_b;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares every due expectation one half-cycle after its edge.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("sb_slot", e.due, cyc);
      chk("locked_a", int'(bus_a.locked), int'(e.locked));
      chk("err_a", int'(bus_a.err), int'(e.err));
      chk("cnt_a", int'(bus_a.err_count), e.cnt_a);
      chk("locked_b", int'(bus_b.locked), int'(e.locked));
      chk("err_b", int'(bus_b.err), int'(e.err));
      chk("cnt_b", int'(bus_b.err_count), e.cnt_b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int g;
  initial begin
    bus_a.en = 1'b0; bus_a.data_in = 8'h00; bus_a.clr_count = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_locked", int'(bus_a.locked), 0);
    chk("reset_err", int'(bus_a.err), 0);
    chk("reset_cnt_a", int'(bus_a.err_count), 0);
    chk("reset_cnt_b", int'(bus_b.err_count), 0);

    // Acquisition from the seed word.
    g = 1;
    beat(1, g, 0);
    repeat (4) begin g = gnext(g); beat(1, g, 0); end

    // Single corrupted word 2C -> 2D, then clean 58, B1.
    g = gnext(g); beat(1, g ^ 8'h01, 0);
    repeat (2) begin g = gnext(g); beat(1, g, 0); end
    drain();
    chk("single_err_cnt", int'(bus_a.err_count), 1);
    chk("single_err_locked", int'(bus_a.locked), 1);

    // Loss of lock on three zero words, then re-acquire.
    repeat (3) beat(1, 0, 0);
    g = 1;
    beat(1, g, 0);
    repeat (4) begin g = gnext(g); beat(1, g, 0); end

    // Clear coinciding with an error beat.
    g = gnext(g); beat(1, g ^ 8'h10, 1);
    g = gnext(g); beat(1, g, 0);

    // Async reset while locked.
    drain();
    rst = 1'b1;
    #1;
    chk("async_rst_locked", int'(bus_a.locked), 0);
    chk("async_rst_cnt", int'(bus_a.err_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Acquisition with bubbles.
    g = 1;
    beat(1, g, 0);
    repeat (8) begin
      beat(0, $urandom_range(0, 255), 0);
      g = gnext(g);
      beat(1, g, 0);
    end

    // Five isolated errors: the 2-bit counter saturates.
    repeat (5) begin
      g = gnext(g); beat(1, g ^ 8'h80, 0);
      g = gnext(g); beat(1, g, 0);
    end

    // Randomised stream against the model.
    for (int i = 0; i < 2000; i++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 49) == 0);
      if (r < 15) begin
        beat(0, $urandom_range(0, 255), c);
      end else if (r < 20) begin
        beat(1, 0, c);
      end else if (r < 28) begin
        g = gnext(g);
        beat(1, g ^ $urandom_range(1, 255), c);
      end else if (r < 30) begin
        g = $urandom_range(1, 255);
        beat(1, g, c);
      end else begin
        g = gnext(g);
        beat(1, g, c);
      end
    end

    bus_a.en = 1'b0;
    bus_a.clr_count = 1'b0;
    drain();
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Receive-side partner of the team's 8-bit Fibonacci LFSR pattern generator.
- Consumes the generator's word stream: one 8-bit word per enabled cycle, each word the generator register after a shift.
- Self-synchronises to the stream, then free-runs its own reference sequence to detect and count corrupted words.
- Used as the on-board loopback/BIST checker for LFSR-driven lab designs.

Parameters:
- LOCK_CNT, 4: consecutive correct predictions in HUNT required to enter LOCKED (≥1).
- UNLOCK_CNT, 3: consecutive mismatches in LOCKED that force return to HUNT (≥1).
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  data_in carries a valid word this cycle.
- data_in  input  8  received generator word.
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err  output  1  one-cycle pulse: previous enabled word mismatched while LOCKED.
- err_count  output  CNT_W  saturating error total.

Behaviour:
- Polynomial is identical to the generator: next(s) = {s[6:0], s[1]^s[2]^s[3]^s[7]}; all-zero is the lock-up word and never legal.
- Internal state:
  - ref: 8-bit reference word.
  - have_ref: 1-bit flag.
  - match_cnt and miss_cnt: sized to hold their parameter values.
  - st: HUNT or LOCKED.
- Reset (async): st=HUNT, ref=0, have_ref=0, match_cnt=0, miss_cnt=0, locked=0, err=0, err_count=0.
- en=0: all state holds; err=0 next cycle.
- Every en=1 beat computes exp = next(ref). All outputs are registered and reflect a beat on the following cycle (latency 1).
- HUNT:
  - data_in==0: have_ref=0, match_cnt=0.
  - Otherwise, if have_ref and data_in==exp: match_cnt+1. Else match_cnt=0.
  - In the nonzero case, always load ref=data_in and set have_ref=1.
  - If the beat matches and match_cnt+1==LOCK_CNT: go to LOCKED, miss_cnt=0, locked=1.
  - err is never asserted in HUNT.
- LOCKED:
  - ref=exp on every beat (free-running), so a single corrupted word does not corrupt the reference.
  - data_in!=exp: err=1, err_count+1 (saturating at all-ones), miss_cnt+1.
  - Match: miss_cnt=0.
  - On a mismatch where miss_cnt+1==UNLOCK_CNT: go to HUNT, locked=0, match_cnt=0. Also ref=data_in and have_ref=(data_in!=0), so re-acquisition starts from that word.
- clr_count has priority over a simultaneous increment (result 0). It is honoured regardless of en or state.
- Reset mid-stream discards lock. The next nonzero beat only seeds ref.

Optional Feature:
- PRBS_CHK_BITERR_EN defined: LOCKED mismatches add popcount(data_in ^ exp) (1..8) to err_count, saturating, instead of 1. err pulse rule is unchanged.
- Undefined: word-error counting as above.

Decomposition:
- Package prbs8_pkg holds:
  - localparam LFSR_W=8 and LFSR_SEED=8'h01.
  - Tap mask 8'b1000_1110.
  - typedef enum logic {HUNT, LOCKED} chk_state_t.
  - function lfsr8_next(logic [7:0]).
  - function popcount8.
- The generator is refactored to use lfsr8_next so both ends share one polynomial definition.
- No sub-module. Single always_ff plus combinational next-state logic.

Test Plan:
- Golden sequence is 01,02,05,0B,16,2C,58,B1.
- Acquisition, LOCK_CNT=4: feed 01,02,05,0B,16 on consecutive en beats. locked=0 through the 0B beat response, locked=1 the cycle after 16. err_count=0.
- Single error: after lock, send 2D in place of 2C, then 58, B1. err pulses exactly once, err_count=1, locked stays 1, no err on 58.
- Bit-error mode (PRBS_CHK_BITERR_EN): send D3 in place of 2C. err_count=8. Repeat with 2D → err_count=9.
- Loss of lock, UNLOCK_CNT=3: after lock send 00,00,00. err pulses on each, locked drops after the third, err_count=3. Resume 01,02,05,0B,16 → relocks.
- Bubbles and reset: interleave en=0 cycles within the golden sequence → lock still acquired, no err. Assert rst while locked → locked=0 and err_count=0 immediately (async).
- Counter edges: CNT_W=2, inject 5 errors → err_count saturates at 3. Assert clr_count on the same cycle as an error beat → err_count=0.
